// File: rtl/param_entry_pkg.sv
// Shared state encoding, value width and value-step helper for the button parameter-entry front end.
package param_entry_pkg;

  localparam int VW = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_EDIT_START = 2'd1,
    ST_EDIT_STOP  = 2'd2
  } state_t;

  // inc and dec arriving together cancel out; both directions wrap mod 2**VW
  function automatic logic [VW-1:0] step_val(input logic [VW-1:0] v, input logic inc, input logic dec);
    logic [VW-1:0] r;
    r = v;
    if (inc && !dec)      r = v + 1'b1;
    else if (dec && !inc) r = v - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, DEB_CYCLES stable-sample debounce, registered 1-cycle press pulse.
// press rises DEB_CYCLES+3 edges after a clean raw 0->1; no backpressure, release yields no pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // counter only runs while the sample disagrees with the accepted level
  always_ff @(posedge clk_in) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (sync2 == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      level   <= ~level;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/btn_param_entry.sv
// Debounced inc/dec/mode editing of counter start/stop values; outputs update DEB_CYCLES+4 edges after a raw press.
// No backpressure: every press pulse is acted on (or discarded) in the cycle it appears.
module btn_param_entry
  import param_entry_pkg::*;
#(
  parameter int          DEB_CYCLES   = 1_000_000,
  parameter int          BLINK_CYCLES = 25_000_000,
  parameter logic [VW-1:0] START_RST  = 4'd0,
  parameter logic [VW-1:0] STOP_RST   = 4'd9
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          btn_inc,
  input  logic          btn_dec,
  input  logic          btn_mode,
  output logic [VW-1:0] start_vl,
  output logic [VW-1:0] stop_vl,
  output logic [1:0]    edit_sel,
  output logic          run,
  output logic          blink
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic          inc_p;
  logic          dec_p;
  logic          mode_p;
  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] blink_cnt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk_in(clk_in), .rst(rst), .btn_raw(btn_inc), .level(), .press(inc_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk_in(clk_in), .rst(rst), .btn_raw(btn_dec), .level(), .press(dec_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_in(clk_in), .rst(rst), .btn_raw(btn_mode), .level(), .press(mode_p)
  );

  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_p) begin
      case (state)
        ST_RUN:        state_nxt = ST_EDIT_START;
        ST_EDIT_START: state_nxt = ST_EDIT_STOP;
        default:       state_nxt = ST_RUN;
      endcase
    end
  end

  // a mode press takes priority; inc/dec in that cycle are dropped
  always_ff @(posedge clk_in) begin
    if (rst) begin
      start_vl <= START_RST;
      stop_vl  <= STOP_RST;
    end else if (!mode_p) begin
      if (state == ST_EDIT_START) start_vl <= step_val(start_vl, inc_p, dec_p);
      if (state == ST_EDIT_STOP)  stop_vl  <= step_val(stop_vl, inc_p, dec_p);
    end
  end

  // restart the blink phase on every state change so the new digit starts visible
  always_ff @(posedge clk_in) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state_nxt != state || state == ST_RUN) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign edit_sel = state;
  assign run      = (state == ST_RUN);

endmodule

// File: tb/tb_btn_param_entry.sv
// Directed bench for btn_param_entry with DEB_CYCLES=4, BLINK_CYCLES=8.
module tb_btn_param_entry;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_mode;
  logic [3:0] start_vl;
  logic [3:0] stop_vl;
  logic [1:0] edit_sel;
  logic       run;
  logic       blink;

  int vecs = 0;
  int errs = 0;

  always #5 clk_in = ~clk_in;

  btn_param_entry #(
    .DEB_CYCLES(4), .BLINK_CYCLES(8), .START_RST(4'd0), .STOP_RST(4'd9)
  ) dut (
    .clk_in(clk_in), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_mode(btn_mode),
    .start_vl(start_vl), .stop_vl(stop_vl), .edit_sel(edit_sel), .run(run), .blink(blink)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // hold the given buttons long enough to be accepted, then release and let the release settle
  task automatic press(input logic i, input logic d, input logic m);
    btn_inc = i; btn_dec = d; btn_mode = m;
    tick(10);
    btn_inc = 1'b0; btn_dec = 1'b0; btn_mode = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0; btn_mode = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    vecs++; if (start_vl !== 4'd0) begin errs++; $display("FAIL reset_start got=%0d exp=0", start_vl); end
    vecs++; if (stop_vl !== 4'd9) begin errs++; $display("FAIL reset_stop got=%0d exp=9", stop_vl); end
    vecs++; if (edit_sel !== 2'd0) begin errs++; $display("FAIL reset_sel got=%0d exp=0", edit_sel); end
    vecs++; if (run !== 1'b1) begin errs++; $display("FAIL reset_run got=%b exp=1", run); end
    vecs++; if (blink !== 1'b0) begin errs++; $display("FAIL reset_blink got=%b exp=0", blink); end
  endtask

  task automatic test_run_ignore_and_mode_latency;
    btn_inc = 1'b1;
    tick(20);
    btn_inc = 1'b0;
    tick(10);
    vecs++; if (start_vl !== 4'd0) begin errs++; $display("FAIL run_inc_start got=%0d exp=0", start_vl); end
    vecs++; if (stop_vl !== 4'd9) begin errs++; $display("FAIL run_inc_stop got=%0d exp=9", stop_vl); end
    btn_mode = 1'b1;
    tick(7);
    vecs++; if (edit_sel !== 2'd0) begin errs++; $display("FAIL mode_early got=%0d exp=0", edit_sel); end
    tick(1);
    vecs++; if (edit_sel !== 2'd1) begin errs++; $display("FAIL mode_at_8 got=%0d exp=1", edit_sel); end
    vecs++; if (run !== 1'b0) begin errs++; $display("FAIL mode_run got=%b exp=0", run); end
    btn_mode = 1'b0;
    tick(10);
  endtask

  task automatic test_edit_start;
    press(1'b0, 1'b1, 1'b0);
    vecs++; if (start_vl !== 4'd15) begin errs++; $display("FAIL dec_wrap got=%0d exp=15", start_vl); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    vecs++; if (start_vl !== 4'd1) begin errs++; $display("FAIL inc_wrap got=%0d exp=1", start_vl); end
    btn_inc = 1'b1;
    tick(3);
    btn_inc = 1'b0;
    tick(12);
    vecs++; if (start_vl !== 4'd1) begin errs++; $display("FAIL glitch got=%0d exp=1", start_vl); end
  endtask

  task automatic test_edit_stop;
    press(1'b0, 1'b0, 1'b1);
    vecs++; if (edit_sel !== 2'd2) begin errs++; $display("FAIL to_stop got=%0d exp=2", edit_sel); end
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 1'b0);
    vecs++; if (stop_vl !== 4'd0) begin errs++; $display("FAIL stop_wrap got=%0d exp=0", stop_vl); end
    vecs++; if (start_vl !== 4'd1) begin errs++; $display("FAIL stop_keeps_start got=%0d exp=1", start_vl); end
    press(1'b0, 1'b0, 1'b1);
    vecs++; if (edit_sel !== 2'd0) begin errs++; $display("FAIL back_run got=%0d exp=0", edit_sel); end
    vecs++; if (run !== 1'b1) begin errs++; $display("FAIL back_run_run got=%b exp=1", run); end
    vecs++; if (blink !== 1'b0) begin errs++; $display("FAIL back_run_blink got=%b exp=0", blink); end
  endtask

  task automatic test_simultaneous;
    press(1'b0, 1'b0, 1'b1);
    vecs++; if (edit_sel !== 2'd1) begin errs++; $display("FAIL sim_enter got=%0d exp=1", edit_sel); end
    press(1'b1, 1'b1, 1'b0);
    vecs++; if (start_vl !== 4'd1) begin errs++; $display("FAIL inc_dec_same got=%0d exp=1", start_vl); end
    press(1'b1, 1'b0, 1'b1);
    vecs++; if (edit_sel !== 2'd2) begin errs++; $display("FAIL mode_inc_sel got=%0d exp=2", edit_sel); end
    vecs++; if (start_vl !== 4'd1) begin errs++; $display("FAIL mode_inc_start got=%0d exp=1", start_vl); end
    vecs++; if (stop_vl !== 4'd0) begin errs++; $display("FAIL mode_inc_stop got=%0d exp=0", stop_vl); end
  endtask

  task automatic test_reset_mid_edit_and_blink;
    logic exp_b;
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0);
    vecs++; if (stop_vl !== 4'd5) begin errs++; $display("FAIL pre_rst_stop got=%0d exp=5", stop_vl); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    vecs++; if (stop_vl !== 4'd9) begin errs++; $display("FAIL rst_mid_stop got=%0d exp=9", stop_vl); end
    vecs++; if (edit_sel !== 2'd0) begin errs++; $display("FAIL rst_mid_sel got=%0d exp=0", edit_sel); end
    vecs++; if (start_vl !== 4'd0) begin errs++; $display("FAIL rst_mid_start got=%0d exp=0", start_vl); end
    for (int k = 0; k < 20; k++) begin
      tick(1);
      vecs++; if (blink !== 1'b0) begin errs++; $display("FAIL blink_run k=%0d got=%b exp=0", k, blink); end
    end
    btn_mode = 1'b1;
    tick(8);
    vecs++; if (edit_sel !== 2'd1) begin errs++; $display("FAIL blink_enter got=%0d exp=1", edit_sel); end
    for (int k = 0; k <= 24; k++) begin
      exp_b = ((k / 8) % 2) == 1;
      vecs++; if (blink !== exp_b) begin errs++; $display("FAIL blink_edit k=%0d got=%b exp=%b", k, blink, exp_b); end
      tick(1);
    end
    btn_mode = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset;
    test_run_ignore_and_mode_latency;
    test_edit_start;
    test_edit_stop;
    test_simultaneous;
    test_reset_mid_edit_and_blink;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
